// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_counter_bank
// Purpose  : WIDTH-bit JK register bank that doubles as a modulo-MOD up/down
//            counter with parallel load. Define JK_CNT_SAT_EN for saturating
//            counting instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module jk_counter_bank #(
   parameter int WIDTH     = 4,
   parameter int MOD       = 16,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             tc,
   output logic             wrap
);

   localparam logic [1:0]       c_mode_jk   = 2'b00;
   localparam logic [1:0]       c_mode_up   = 2'b01;
   localparam logic [1:0]       c_mode_down = 2'b10;
   localparam logic [1:0]       c_mode_load = 2'b11;
   localparam logic [WIDTH-1:0] c_max       = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] c_zero      = '0;
   localparam logic [WIDTH-1:0] c_rst       = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_wrap_nxt;

   // "Out of range" is Q >= MOD, i.e. Q > MOD-1 at WIDTH bits.
   always_comb begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      if (en) begin
         case (mode)
            c_mode_jk: begin
               w_q_nxt = (J & ~r_q) | (~K & r_q);
            end
            c_mode_up: begin
               if (r_q >= c_max) begin
                  w_wrap_nxt = 1'b1;
`ifdef JK_CNT_SAT_EN
                  w_q_nxt    = c_max;
`else
                  w_q_nxt    = c_zero;
`endif
               end else begin
                  w_q_nxt = r_q + 1'b1;
               end
            end
            c_mode_down: begin
               if (r_q == c_zero) begin
                  w_wrap_nxt = 1'b1;
`ifdef JK_CNT_SAT_EN
                  w_q_nxt    = c_zero;
`else
                  w_q_nxt    = c_max;
`endif
               end else if (r_q > c_max) begin
                  w_wrap_nxt = 1'b1;
                  w_q_nxt    = c_max;
               end else begin
                  w_q_nxt = r_q - 1'b1;
               end
            end
            c_mode_load: begin
               if (d <= c_max) begin
                  w_q_nxt = d;
               end
            end
            default: begin
               w_q_nxt = r_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q    <= c_rst;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign Q    = r_q;
   assign Qbar = ~r_q;
   assign wrap = r_wrap;
   assign tc   = ((mode == c_mode_up)   && (r_q == c_max)) ||
                 ((mode == c_mode_down) && (r_q == c_zero));

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_counter_bank
// Purpose  : Directed plus random checks of jk_counter_bank (WIDTH=4, MOD=10)
//            against an integer reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_counter_bank;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;
`ifdef JK_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] J, K, d;
   logic [WIDTH-1:0] Q, Qbar;
   logic             tc, wrap;

   int tests = 0;
   int fails = 0;
   int m_q   = 0;
   bit m_w   = 1'b0;

   jk_counter_bank #(.WIDTH(WIDTH), .MOD(MOD), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode),
      .J(J), .K(K), .d(d), .Q(Q), .Qbar(Qbar), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag);
      logic [WIDTH-1:0] eq;
      logic             etc;
      eq  = WIDTH'(m_q);
      etc = ((mode == 2'b01) && (m_q == MOD - 1)) || ((mode == 2'b10) && (m_q == 0));
      tests++;
      assert (Q === eq) else begin
         fails++; $error("FAIL %s Q observed=%0d expected=%0d", tag, Q, eq);
      end
      tests++;
      assert (Qbar === ~eq) else begin
         fails++; $error("FAIL %s Qbar observed=%b expected=%b", tag, Qbar, ~eq);
      end
      tests++;
      assert (wrap === m_w) else begin
         fails++; $error("FAIL %s wrap observed=%b expected=%b", tag, wrap, m_w);
      end
      tests++;
      assert (tc === etc) else begin
         fails++; $error("FAIL %s tc observed=%b expected=%b", tag, tc, etc);
      end
   endtask

   // One clock edge with the given inputs, then model update and check.
   task automatic step(input logic e, input logic [1:0] m, input logic [WIDTH-1:0] j,
                       input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] dd,
                       input string tag);
      en = e; mode = m; J = j; K = k; d = dd;
      @(posedge clk);
      m_w = 1'b0;
      if (e) begin
         case (m)
            2'b00: for (int i = 0; i < WIDTH; i++) begin
               if (j[i] && k[i])  m_q = m_q ^ (1 << i);
               else if (j[i])     m_q = m_q | (1 << i);
               else if (k[i])     m_q = m_q & ~(1 << i);
            end
            2'b01: if (m_q >= MOD - 1) begin
               m_w = 1'b1;
               m_q = SAT ? MOD - 1 : 0;
            end else m_q = m_q + 1;
            2'b10: if (m_q == 0 || m_q >= MOD) begin
               m_w = 1'b1;
               m_q = (SAT && m_q == 0) ? 0 : MOD - 1;
            end else m_q = m_q - 1;
            default: if (int'(dd) < MOD) m_q = int'(dd);
         endcase
      end
      #1;
      chk(tag);
   endtask

   // Asynchronous reset in the middle of the high clock phase.
   task automatic mid_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      m_q = 0; m_w = 1'b0;
      chk(tag);
      #3 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; mode = 2'b00; J = '0; K = '0; d = '0;
      #2;
      chk("reset_start");
      mode = 2'b10;
      #1 chk("reset_tc_down");
      mode = 2'b00;
      #4 reset = 1'b0;

      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd7, "load7");
      mid_reset("reset_mid");

      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd5, "load5");
      step(1'b1, 2'b00, 4'b1100, 4'b1010, 4'h0, "jk_mix");

      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd0, "load0");
      for (int i = 0; i < 10; i++) step(1'b1, 2'b01, 4'h0, 4'h0, 4'h0, "count_up");

      step(1'b1, 2'b10, 4'h0, 4'h0, 4'h0, "down_wrap");
      for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 4'h0, 4'h0, 4'h0, "en_low");
      for (int i = 0; i < 2; i++) step(1'b1, 2'b10, 4'h0, 4'h0, 4'h0, "down_step");

      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd12, "load_oor");
      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd6,  "load6");
      step(1'b1, 2'b00, 4'hF, 4'h0, 4'h0,  "jk_set15");
      mode = 2'b01; #1 chk("tc_comb_up15");
      step(1'b1, 2'b01, 4'h0, 4'h0, 4'h0,  "up_from15");
      mode = 2'b10; #1 chk("tc_comb_down0");
      step(1'b1, 2'b00, 4'hC, 4'h0, 4'h0,  "jk_set12");
      step(1'b1, 2'b10, 4'h0, 4'h0, 4'h0,  "down_from12");

      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd8, "load8");
      for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 4'h0, 4'h0, 4'h0, "up_from8");
      step(1'b1, 2'b11, 4'h0, 4'h0, 4'd0, "load0b");
      step(1'b1, 2'b10, 4'h0, 4'h0, 4'h0, "down_from0");

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              4'($urandom), 4'($urandom), 4'($urandom), "random");
         if ($urandom_range(0, 49) == 0) mid_reset("random_reset");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
